// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if: data-memory request/ready bus between the MEM stage and data memory
interface mem_access_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  modport master(output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, input dmem_ready, dmem_rdata);
  modport slave(input dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, output dmem_ready, dmem_rdata);
endinterface

// File: rtl/mem_access_stage.sv
// mem_access_stage: pipeline MEM stage doing sized aligned loads/stores over a req/ready bus
module mem_access_stage #(
  parameter int MAX_WAIT = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic                      in_MemWrite,
  input  logic                      in_MemRead,
  input  logic                      in_RegWrite,
  input  logic [4:0]                in_RegDest,
  input  logic                      in_MemToReg,
  input  logic [2:0]                in_MemSize,
  input  logic [31:0]               in_AluResult,
  input  logic [31:0]               in_StoreData,
  output logic                      stall,
  mem_access_stage_if.master        mem,
  output logic                      out_valid,
  output logic                      out_RegWrite,
  output logic [4:0]                out_RegDest,
  output logic                      out_MemToReg,
  output logic [31:0]               out_data_out,
  output logic [31:0]               out_AluResult,
  output logic                      out_fault,
  output logic [1:0]                out_fault_cause
);
  localparam int CW = MAX_WAIT > 1 ? $clog2(MAX_WAIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t      state_q;
  logic [CW-1:0] cnt_q;
  logic        ctx_rw_q, ctx_we_q, ctx_m2r_q;
  logic [4:0]  ctx_dst_q;
  logic [2:0]  ctx_size_q;
  logic [31:0] ctx_alu_q;
  logic        mem_op, illegal, misal, rw_d, timeout;
  logic [1:0]  s, cause_d;
  logic [3:0]  be_d;
  logic [31:0] wdata_d, ld_d;
  logic [15:0] lane;
  assign stall = (state_q == WAIT);
  // Decode the incoming op (legality, lanes) and extract load data from the latched request
  always_comb begin
    s = in_AluResult[1:0];
    mem_op = in_MemRead | in_MemWrite;
    illegal = mem_op & ((in_MemRead & in_MemWrite) | (in_MemSize == 3'b011) | (in_MemSize[2:1] == 2'b11) | (in_MemWrite & in_MemSize[2]));
    misal = mem_op & (((in_MemSize[1:0] == 2'b01) & s[0]) | ((in_MemSize[1:0] == 2'b10) & (s != 2'b00)));
    cause_d = illegal ? 2'b11 : misal ? 2'b01 : 2'b00;
    rw_d = in_RegWrite & (in_RegDest != 5'd0);
    be_d = ~in_MemWrite ? 4'b0000 : (in_MemSize[1:0] == 2'b00) ? 4'b0001 << s : (in_MemSize[1:0] == 2'b01) ? 4'b0011 << s : 4'b1111;
    wdata_d = ~in_MemWrite ? 32'd0 : (in_MemSize[1:0] == 2'b00) ? {4{in_StoreData[7:0]}} : (in_MemSize[1:0] == 2'b01) ? {2{in_StoreData[15:0]}} : in_StoreData;
    lane = 16'(mem.dmem_rdata >> {ctx_alu_q[1:0], 3'b000});
    ld_d = (ctx_size_q[1:0] == 2'b00) ? {{24{~ctx_size_q[2] & lane[7]}}, lane[7:0]} : (ctx_size_q[1:0] == 2'b01) ? {{16{~ctx_size_q[2] & lane[15]}}, lane} : mem.dmem_rdata;
    timeout = (MAX_WAIT != 0) && (cnt_q == LAST);
  end
  // IDLE/WAIT controller owning the memory request and the MEM/WB register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      ctx_rw_q <= 1'b0;
      ctx_we_q <= 1'b0;
      ctx_m2r_q <= 1'b0;
      ctx_dst_q <= '0;
      ctx_size_q <= '0;
      ctx_alu_q <= '0;
      mem.dmem_req <= 1'b0;
      mem.dmem_we <= 1'b0;
      mem.dmem_addr <= '0;
      mem.dmem_wdata <= '0;
      mem.dmem_be <= '0;
      out_valid <= 1'b0;
      out_RegWrite <= 1'b0;
      out_RegDest <= '0;
      out_MemToReg <= 1'b0;
      out_data_out <= '0;
      out_AluResult <= '0;
      out_fault <= 1'b0;
      out_fault_cause <= '0;
    end else if (state_q == IDLE) begin
      out_valid <= in_valid & (~mem_op | (cause_d != 2'b00));
      out_RegWrite <= in_valid & ~mem_op & rw_d;
      out_fault <= in_valid & (cause_d != 2'b00);
      out_fault_cause <= in_valid ? cause_d : 2'b00;
      out_data_out <= '0;
      if (in_valid) begin
        out_RegDest <= in_RegDest;
        out_MemToReg <= in_MemToReg;
        out_AluResult <= in_AluResult;
      end
      if (in_valid & mem_op & (cause_d == 2'b00)) begin
        state_q <= WAIT;
        cnt_q <= '0;
        mem.dmem_req <= 1'b1;
        mem.dmem_we <= in_MemWrite;
        mem.dmem_addr <= {in_AluResult[31:2], 2'b00};
        mem.dmem_wdata <= wdata_d;
        mem.dmem_be <= be_d;
        ctx_rw_q <= in_MemRead & rw_d;
        ctx_we_q <= in_MemWrite;
        ctx_m2r_q <= in_MemToReg;
        ctx_dst_q <= in_RegDest;
        ctx_size_q <= in_MemSize;
        ctx_alu_q <= in_AluResult;
      end
    end else if (mem.dmem_ready | timeout) begin
      state_q <= IDLE;
      mem.dmem_req <= 1'b0;
      out_valid <= 1'b1;
      out_RegWrite <= mem.dmem_ready & ctx_rw_q;
      out_RegDest <= ctx_dst_q;
      out_MemToReg <= ctx_m2r_q;
      out_AluResult <= ctx_alu_q;
      out_data_out <= (mem.dmem_ready & ~ctx_we_q) ? ld_d : 32'd0;
      out_fault <= ~mem.dmem_ready;
      out_fault_cause <= mem.dmem_ready ? 2'b00 : 2'b10;
    end else begin
      cnt_q <= cnt_q + CW'(1);
      out_valid <= 1'b0;
      out_RegWrite <= 1'b0;
      out_fault <= 1'b0;
      out_fault_cause <= 2'b00;
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed and randomized checks of the MEM stage against a behavioural model
module tb_mem_access_stage;
  localparam int MAXW = 4;
  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_MemWrite, in_MemRead, in_RegWrite, in_MemToReg;
  logic [4:0] in_RegDest;
  logic [2:0] in_MemSize;
  logic [31:0] in_AluResult, in_StoreData;
  logic stall, out_valid, out_RegWrite, out_MemToReg, out_fault;
  logic [4:0] out_RegDest;
  logic [31:0] out_data_out, out_AluResult;
  logic [1:0] out_fault_cause;
  int checks = 0;
  int failures = 0;
  logic obs_done, obs_req, obs_we, obs_held, obs_valid, obs_rw, obs_m2r, obs_fault, obs_stall_after;
  logic [3:0] obs_be;
  logic [4:0] obs_dst;
  logic [1:0] obs_cause;
  logic [31:0] obs_addr, obs_wdata, obs_data, obs_alu;
  int obs_stall, obs_lat;
  logic e_req, e_fault, e_rw;
  logic [1:0] e_cause;
  logic [3:0] e_be;
  logic [31:0] e_addr, e_wdata, e_data;
  int e_lat;

  always #5 clk = ~clk;

  mem_access_stage_if mif();

  mem_access_stage #(.MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_MemWrite(in_MemWrite), .in_MemRead(in_MemRead), .in_RegWrite(in_RegWrite),
    .in_RegDest(in_RegDest), .in_MemToReg(in_MemToReg), .in_MemSize(in_MemSize),
    .in_AluResult(in_AluResult), .in_StoreData(in_StoreData),
    .stall(stall), .mem(mif),
    .out_valid(out_valid), .out_RegWrite(out_RegWrite), .out_RegDest(out_RegDest), .out_MemToReg(out_MemToReg),
    .out_data_out(out_data_out), .out_AluResult(out_AluResult), .out_fault(out_fault), .out_fault_cause(out_fault_cause)
  );

  // Reference: outcome of one instruction computed from the architectural rules
  function automatic void model(input logic rd, wr, rw, input logic [4:0] dst, input logic [2:0] sz,
                                input logic [31:0] addr, sd, rdat, input int dly);
    int w, off;
    logic mem_op, ill, mis, to;
    logic [31:0] v, mask;
    w = (sz % 4 == 0) ? 1 : (sz % 4 == 1) ? 2 : 4;
    off = int'(addr[1:0]);
    mem_op = rd | wr;
    ill = mem_op && ((rd && wr) || sz == 3 || sz >= 6 || (wr && sz >= 4));
    mis = mem_op && !ill && (off % w != 0);
    e_req = mem_op && !ill && !mis;
    to = e_req && dly >= MAXW;
    e_fault = ill || mis || to;
    e_cause = ill ? 2'd3 : mis ? 2'd1 : to ? 2'd2 : 2'd0;
    e_lat = !e_req ? 0 : to ? MAXW : dly + 1;
    e_addr = addr - 32'(off);
    e_be = wr ? 4'(((1 << w) - 1) << off) : 4'd0;
    e_wdata = (w == 1) ? (sd & 32'hFF) * 32'h01010101 : (w == 2) ? (sd & 32'hFFFF) * 32'h00010001 : sd;
    mask = (w == 4) ? 32'hFFFFFFFF : (32'd1 << (8 * w)) - 32'd1;
    v = (rdat >> (8 * off)) & mask;
    if (w < 4 && sz < 4 && v >= (32'd1 << (8 * w - 1))) v = v - (32'd1 << (8 * w));
    e_data = (rd && e_req && !to) ? v : 32'd0;
    e_rw = !e_fault && !wr && rw && dst != 5'd0;
  endfunction

  // Issue one instruction, play memory with the given ready delay, record what the DUT did
  task automatic do_op(input logic rd, wr, rw, input logic [4:0] dst, input logic m2r, input logic [2:0] sz,
                       input logic [31:0] addr, sd, rdat, input int dly);
    logic done;
    @(negedge clk);
    in_valid = 1'b1; in_MemRead = rd; in_MemWrite = wr; in_RegWrite = rw; in_RegDest = dst;
    in_MemToReg = m2r; in_MemSize = sz; in_AluResult = addr; in_StoreData = sd;
    mif.dmem_ready = 1'b0;
    @(posedge clk); #1;
    obs_req = mif.dmem_req; obs_we = mif.dmem_we; obs_addr = mif.dmem_addr;
    obs_wdata = mif.dmem_wdata; obs_be = mif.dmem_be;
    obs_stall = int'(stall); obs_lat = 0; obs_held = 1'b1;
    done = out_valid;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      {in_valid, in_MemRead, in_MemWrite, in_RegWrite, in_MemToReg} = 5'($urandom);
      in_RegDest = 5'($urandom); in_MemSize = 3'($urandom);
      in_AluResult = $urandom; in_StoreData = $urandom;
      mif.dmem_ready = (k >= dly);
      mif.dmem_rdata = (k >= dly) ? rdat : $urandom;
      @(posedge clk); #1;
      obs_lat++;
      if (out_valid) done = 1'b1;
      else begin
        obs_stall += int'(stall);
        if (mif.dmem_req !== 1'b1 || mif.dmem_addr !== obs_addr || mif.dmem_we !== obs_we ||
            mif.dmem_be !== obs_be || mif.dmem_wdata !== obs_wdata) obs_held = 1'b0;
      end
    end
    obs_done = done; obs_valid = out_valid; obs_rw = out_RegWrite; obs_dst = out_RegDest;
    obs_m2r = out_MemToReg; obs_data = out_data_out; obs_alu = out_AluResult;
    obs_fault = out_fault; obs_cause = out_fault_cause; obs_stall_after = stall;
    @(negedge clk);
    in_valid = 1'b0; mif.dmem_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    in_valid = 1'b0; in_MemRead = 1'b0; in_MemWrite = 1'b0; in_RegWrite = 1'b0; in_RegDest = '0;
    in_MemToReg = 1'b0; in_MemSize = '0; in_AluResult = '0; in_StoreData = '0;
    mif.dmem_ready = 1'b0; mif.dmem_rdata = '0;
    #22;
    checks++;
    if ({out_valid, out_RegWrite, out_fault, out_fault_cause} !== 5'd0) begin
      failures++; $display("FAIL reset_flags got=%b exp=00000", {out_valid, out_RegWrite, out_fault, out_fault_cause});
    end
    checks++;
    if ({out_data_out, out_AluResult} !== 64'd0) begin
      failures++; $display("FAIL reset_data got=%h exp=0", {out_data_out, out_AluResult});
    end
    checks++;
    if ({mif.dmem_req, mif.dmem_we, mif.dmem_be, mif.dmem_addr} !== 38'd0) begin
      failures++; $display("FAIL reset_dmem got=%h exp=0", {mif.dmem_req, mif.dmem_we, mif.dmem_be, mif.dmem_addr});
    end
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_idle_invalid;
    @(negedge clk);
    in_valid = 1'b0; in_MemRead = 1'b1; in_RegWrite = 1'b1; in_RegDest = 5'd4;
    @(posedge clk); #1;
    checks++;
    if ({out_valid, out_RegWrite, mif.dmem_req, stall} !== 4'b0000) begin
      failures++; $display("FAIL idle_invalid got=%b exp=0000", {out_valid, out_RegWrite, mif.dmem_req, stall});
    end
    in_MemRead = 1'b0;
  endtask

  task automatic test_loads;
    do_op(1'b1, 1'b0, 1'b1, 5'd3, 1'b1, 3'b010, 32'h100, 32'd0, 32'hDEADBEEF, 2);
    checks++;
    if (obs_data !== 32'hDEADBEEF || obs_rw !== 1'b1 || obs_fault !== 1'b0) begin
      failures++; $display("FAIL lw_result got data=%h rw=%b fault=%b exp data=deadbeef rw=1 fault=0", obs_data, obs_rw, obs_fault);
    end
    checks++;
    if (obs_stall !== 3 || obs_lat !== 3 || obs_stall_after !== 1'b0) begin
      failures++; $display("FAIL lw_stall got stall=%0d lat=%0d after=%b exp 3 3 0", obs_stall, obs_lat, obs_stall_after);
    end
    checks++;
    if (obs_addr !== 32'h100 || obs_held !== 1'b1 || obs_we !== 1'b0 || obs_be !== 4'd0) begin
      failures++; $display("FAIL lw_bus got addr=%h held=%b we=%b be=%b exp 100 1 0 0000", obs_addr, obs_held, obs_we, obs_be);
    end
    do_op(1'b1, 1'b0, 1'b1, 5'd8, 1'b1, 3'b000, 32'h103, 32'd0, 32'h80FF0000, 0);
    checks++;
    if (obs_data !== 32'hFFFFFF80 || obs_lat !== 1) begin
      failures++; $display("FAIL lb got=%h lat=%0d exp=ffffff80 lat=1", obs_data, obs_lat);
    end
    do_op(1'b1, 1'b0, 1'b1, 5'd8, 1'b1, 3'b100, 32'h103, 32'd0, 32'h80FF0000, 1);
    checks++;
    if (obs_data !== 32'h00000080) begin failures++; $display("FAIL lbu got=%h exp=00000080", obs_data); end
    do_op(1'b1, 1'b0, 1'b1, 5'd9, 1'b1, 3'b001, 32'h102, 32'd0, 32'h80FF0000, 0);
    checks++;
    if (obs_data !== 32'hFFFF80FF) begin failures++; $display("FAIL lh got=%h exp=ffff80ff", obs_data); end
  endtask

  task automatic test_store;
    do_op(1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 3'b001, 32'h102, 32'h1234ABCD, 32'hFFFFFFFF, 1);
    checks++;
    if (obs_we !== 1'b1 || obs_be !== 4'b1100 || obs_addr !== 32'h100) begin
      failures++; $display("FAIL sh_bus got we=%b be=%b addr=%h exp 1 1100 100", obs_we, obs_be, obs_addr);
    end
    checks++;
    if (obs_wdata !== 32'hABCDABCD) begin failures++; $display("FAIL sh_wdata got=%h exp=abcdabcd", obs_wdata); end
    checks++;
    if (obs_rw !== 1'b0 || obs_data !== 32'd0 || obs_valid !== 1'b1) begin
      failures++; $display("FAIL sh_wb got rw=%b data=%h valid=%b exp 0 0 1", obs_rw, obs_data, obs_valid);
    end
  endtask

  task automatic test_faults;
    do_op(1'b1, 1'b0, 1'b1, 5'd2, 1'b1, 3'b010, 32'h101, 32'd0, 32'd0, 0);
    checks++;
    if (obs_req !== 1'b0 || obs_fault !== 1'b1 || obs_cause !== 2'b01 || obs_rw !== 1'b0 || obs_lat !== 0) begin
      failures++; $display("FAIL misaligned got req=%b fault=%b cause=%b rw=%b lat=%0d exp 0 1 01 0 0", obs_req, obs_fault, obs_cause, obs_rw, obs_lat);
    end
    do_op(1'b1, 1'b0, 1'b1, 5'd2, 1'b1, 3'b011, 32'h100, 32'd0, 32'd0, 0);
    checks++;
    if (obs_req !== 1'b0 || obs_fault !== 1'b1 || obs_cause !== 2'b11 || obs_rw !== 1'b0) begin
      failures++; $display("FAIL illegal_size got req=%b fault=%b cause=%b rw=%b exp 0 1 11 0", obs_req, obs_fault, obs_cause, obs_rw);
    end
    do_op(1'b1, 1'b1, 1'b1, 5'd2, 1'b0, 3'b010, 32'h100, 32'd0, 32'd0, 0);
    checks++;
    if (obs_req !== 1'b0 || obs_cause !== 2'b11) begin
      failures++; $display("FAIL illegal_rdwr got req=%b cause=%b exp 0 11", obs_req, obs_cause);
    end
    do_op(1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 3'b100, 32'h100, 32'd5, 32'd0, 0);
    checks++;
    if (obs_req !== 1'b0 || obs_cause !== 2'b11) begin
      failures++; $display("FAIL illegal_sbu got req=%b cause=%b exp 0 11", obs_req, obs_cause);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    in_valid = 1'b1; in_MemRead = 1'b0; in_MemWrite = 1'b0; in_RegWrite = 1'b1; in_MemToReg = 1'b0;
    in_RegDest = 5'd5; in_AluResult = 32'd42; in_MemSize = 3'b010;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_AluResult !== 32'd42 || out_RegDest !== 5'd5 || out_RegWrite !== 1'b1 || stall !== 1'b0 || out_data_out !== 32'd0) begin
      failures++; $display("FAIL b2b_first got valid=%b alu=%0d dst=%0d rw=%b stall=%b data=%h exp 1 42 5 1 0 0", out_valid, out_AluResult, out_RegDest, out_RegWrite, stall, out_data_out);
    end
    @(negedge clk);
    in_RegDest = 5'd6; in_AluResult = 32'd7;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_AluResult !== 32'd7 || out_RegDest !== 5'd6 || stall !== 1'b0) begin
      failures++; $display("FAIL b2b_second got valid=%b alu=%0d dst=%0d stall=%b exp 1 7 6 0", out_valid, out_AluResult, out_RegDest, stall);
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || out_RegWrite !== 1'b0) begin
      failures++; $display("FAIL b2b_drain got valid=%b rw=%b exp 0 0", out_valid, out_RegWrite);
    end
  endtask

  task automatic test_timeout;
    do_op(1'b1, 1'b0, 1'b1, 5'd4, 1'b1, 3'b010, 32'h100, 32'd0, 32'h12345678, 50);
    checks++;
    if (obs_done !== 1'b1 || obs_fault !== 1'b1 || obs_cause !== 2'b10 || obs_rw !== 1'b0 || obs_data !== 32'd0) begin
      failures++; $display("FAIL timeout got done=%b fault=%b cause=%b rw=%b data=%h exp 1 1 10 0 0", obs_done, obs_fault, obs_cause, obs_rw, obs_data);
    end
    checks++;
    if (obs_lat !== MAXW || obs_stall !== MAXW) begin
      failures++; $display("FAIL timeout_len got lat=%0d stall=%0d exp %0d", obs_lat, obs_stall, MAXW);
    end
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    in_valid = 1'b1; in_MemRead = 1'b1; in_MemWrite = 1'b0; in_RegWrite = 1'b1; in_RegDest = 5'd10;
    in_MemSize = 3'b010; in_AluResult = 32'h200; mif.dmem_ready = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (mif.dmem_req !== 1'b1 || stall !== 1'b1) begin
      failures++; $display("FAIL arst_pre got req=%b stall=%b exp 1 1", mif.dmem_req, stall);
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    checks++;
    if (mif.dmem_req !== 1'b0 || stall !== 1'b0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL arst_mid got req=%b stall=%b valid=%b exp 0 0 0", mif.dmem_req, stall, out_valid);
    end
    @(negedge clk);
    rst = 1'b1;
    do_op(1'b1, 1'b0, 1'b1, 5'd11, 1'b1, 3'b010, 32'h104, 32'd0, 32'h11223344, 1);
    checks++;
    if (obs_data !== 32'h11223344 || obs_rw !== 1'b1 || obs_lat !== 2 || obs_fault !== 1'b0) begin
      failures++; $display("FAIL arst_after got data=%h rw=%b lat=%0d fault=%b exp 11223344 1 2 0", obs_data, obs_rw, obs_lat, obs_fault);
    end
  endtask

  task automatic test_random;
    logic [2:0] szs [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    for (int n = 0; n < 80; n++) begin
      logic rd, wr, rw, m2r;
      logic [4:0] dst;
      logic [2:0] sz;
      logic [31:0] a, sd, rdat;
      int r, dly;
      r = int'($urandom % 10);
      rd = (r < 4) || (r == 9);
      wr = (r >= 4 && r < 7) || (r == 9);
      rw = 1'($urandom); m2r = 1'($urandom);
      dst = 5'($urandom);
      if ($urandom % 5 == 0) dst = 5'd0;
      sz = ($urandom % 8 == 0) ? 3'($urandom) : szs[$urandom % 5];
      a = $urandom;
      if ($urandom % 3 != 0) a[1:0] = (sz[1:0] == 2'b00) ? a[1:0] : (sz[1:0] == 2'b01) ? {a[1], 1'b0} : 2'b00;
      sd = $urandom; rdat = $urandom;
      dly = int'($urandom % 6);
      model(rd, wr, rw, dst, sz, a, sd, rdat, dly);
      do_op(rd, wr, rw, dst, m2r, sz, a, sd, rdat, dly);
      checks++;
      if (obs_done !== 1'b1 || obs_valid !== 1'b1 || obs_fault !== e_fault || obs_cause !== e_cause) begin
        failures++; $display("FAIL rnd%0d_status got done=%b valid=%b fault=%b cause=%b exp 1 1 %b %b", n, obs_done, obs_valid, obs_fault, obs_cause, e_fault, e_cause);
      end
      checks++;
      if (obs_rw !== e_rw || obs_data !== e_data || obs_req !== e_req || obs_lat !== e_lat || obs_stall !== e_lat) begin
        failures++; $display("FAIL rnd%0d_result got rw=%b data=%h req=%b lat=%0d stall=%0d exp %b %h %b %0d %0d", n, obs_rw, obs_data, obs_req, obs_lat, obs_stall, e_rw, e_data, e_req, e_lat, e_lat);
      end
      if (e_req) begin
        checks++;
        if (obs_addr !== e_addr || obs_we !== wr || obs_be !== e_be || obs_held !== 1'b1 || (wr && obs_wdata !== e_wdata)) begin
          failures++; $display("FAIL rnd%0d_bus got addr=%h we=%b be=%b held=%b wdata=%h exp %h %b %b 1 %h", n, obs_addr, obs_we, obs_be, obs_held, obs_wdata, e_addr, wr, e_be, e_wdata);
        end
      end
      if (!e_fault) begin
        checks++;
        if (obs_alu !== a || obs_dst !== dst || obs_m2r !== m2r || obs_stall_after !== 1'b0) begin
          failures++; $display("FAIL rnd%0d_pass got alu=%h dst=%0d m2r=%b stall=%b exp %h %0d %b 0", n, obs_alu, obs_dst, obs_m2r, obs_stall_after, a, dst, m2r);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_idle_invalid;
    test_loads;
    test_store;
    test_faults;
    test_back_to_back;
    test_timeout;
    test_async_reset;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule
